// File: rtl/blit_pkg.sv
// Shared opcode constants, FSM state type and opcode helper for the blit command queue.
package blit_pkg;

   localparam logic [7:0] OpNop     = 8'h00;
   localparam logic [7:0] OpSetDest = 8'h01;
   localparam logic [7:0] OpSetSrc  = 8'h02;
   localparam logic [7:0] OpFill    = 8'h03;
   localparam logic [7:0] OpCopy    = 8'h04;
   localparam logic [7:0] OpCopyRev = 8'h05;
   localparam logic [7:0] OpSetClip = 8'h06;
   localparam logic [7:0] OpSetTrans = 8'h07;
   localparam logic [7:0] OpSetFont = 8'h08;
   localparam logic [7:0] OpChar    = 8'h09;
   localparam logic [7:0] OpLine    = 8'h0A;
   localparam logic [7:0] OpFence   = 8'h0B;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} blit_state_e;

   // Draw opcodes are the ones that start an engine and must wait for completion.
   function automatic logic is_draw(input logic [7:0] op);
      return op inside {OpFill, OpCopy, OpCopyRev, OpChar, OpLine};
   endfunction

endpackage

// File: rtl/blit_cmd_fifo.sv
// Command FIFO: synchronous reset, registered occupancy, head word visible without a pop.
module blit_cmd_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_ready,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0]   LevelFull = (PtrW + 1)'(DEPTH);
   localparam logic [PtrW:0]   LevelOne  = (PtrW + 1)'(1);
   localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign wr_ready = (level != LevelFull);
   assign empty    = (level == '0);
   assign do_push  = push && wr_ready;
   assign do_pop   = pop && !empty;
   assign rd_data  = mem_q[rd_ptr_q];

   // Storage array; no reset needed since contents are only read when occupancy says valid.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

   // Pointers wrap naturally at DEPTH (power of two); level tracks push/pop balance.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
         unique case ({do_push, do_pop})
            2'b10:   level <= level + LevelOne;
            2'b01:   level <= level - LevelOne;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/blit_cmd_queue.sv
// Blitter command queue: buffers commands, applies context updates and issues draw commands.
module blit_cmd_queue
   import blit_pkg::*;
#(
   parameter int unsigned CW    = 16,
   parameter int unsigned AW    = 26,
   parameter int unsigned PW    = 9,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   stall,
   input  logic [8+6*CW-1:0]      cmd_in,
   input  logic                   cmd_in_valid,
   output logic                   cmd_in_ready,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   run_line,
   output logic                   run_rect,
   output logic [CW-1:0]          x1,
   output logic [CW-1:0]          y1,
   output logic [CW-1:0]          x2,
   output logic [CW-1:0]          y2,
   output logic [CW-1:0]          width,
   output logic [CW-1:0]          height,
   output logic                   reversed,
   output logic                   textmode,
   output logic                   mem_read,
   output logic [PW-1:0]          fg_color,
   output logic [PW-1:0]          bg_color,
   output logic [PW-1:0]          trans_color,
   output logic [AW-1:0]          dest_addr,
   output logic [AW-1:0]          src_addr,
   output logic [AW-1:0]          font_addr,
   output logic [CW-1:0]          dest_bpr,
   output logic [CW-1:0]          src_bpr,
   output logic [CW-1:0]          clip_x1,
   output logic [CW-1:0]          clip_y1,
   output logic [CW-1:0]          clip_x2,
   output logic [CW-1:0]          clip_y2,
   output logic [4:0]             font_width,
   output logic [4:0]             font_height,
   output logic [4:0]             font_bpr,
   input  logic                   line_done,
   input  logic                   rect_done,
   output logic                   busy,
   output logic [31:0]            cmd_count,
   output logic                   bad_cmd
);

   localparam int unsigned CmdW = 8 + 6 * CW;

   logic [CmdW-1:0] head;
   logic            fifo_empty;
   logic            pop;
   blit_state_e     state_q;
   logic            line_op_q;

   logic [7:0]      f_op;
   logic [CW-1:0]   f_width, f_height, f_x1, f_y1, f_x2, f_y2;

   assign f_width  = head[0*CW +: CW];
   assign f_height = head[1*CW +: CW];
   assign f_x1     = head[2*CW +: CW];
   assign f_y1     = head[3*CW +: CW];
   assign f_x2     = head[4*CW +: CW];
   assign f_y2     = head[5*CW +: CW];
   assign f_op     = head[6*CW +: 8];

   assign pop  = (state_q == StIdle) && !fifo_empty && !stall;
   assign busy = !fifo_empty || (state_q != StIdle);

   blit_cmd_fifo #(
      .WIDTH(CmdW),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (cmd_in_valid),
      .wr_data (cmd_in),
      .wr_ready(cmd_in_ready),
      .pop     (pop),
      .rd_data (head),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Dispatch FSM: retires set commands in the pop cycle, runs draws through ISSUE and WAIT.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         line_op_q   <= 1'b0;
         run_line    <= 1'b0;
         run_rect    <= 1'b0;
         x1          <= '0;
         y1          <= '0;
         x2          <= '0;
         y2          <= '0;
         width       <= '0;
         height      <= '0;
         reversed    <= 1'b0;
         textmode    <= 1'b0;
         mem_read    <= 1'b0;
         fg_color    <= '0;
         bg_color    <= '0;
         trans_color <= '0;
         dest_addr   <= '0;
         src_addr    <= '0;
         font_addr   <= '0;
         dest_bpr    <= '0;
         src_bpr     <= '0;
         clip_x1     <= '0;
         clip_y1     <= '0;
         clip_x2     <= '0;
         clip_y2     <= '0;
         font_width  <= '0;
         font_height <= '0;
         font_bpr    <= '0;
         cmd_count   <= '0;
         bad_cmd     <= 1'b0;
      end else if (!stall) begin
         unique case (state_q)
            StIdle: begin
               if (!fifo_empty) begin
                  if (is_draw(f_op)) begin
                     x1        <= f_x1;
                     y1        <= f_y1;
                     x2        <= f_x2;
                     y2        <= f_y2;
                     width     <= f_width;
                     height    <= f_height;
                     textmode  <= (f_op == OpChar);
                     mem_read  <= (f_op == OpCopy) || (f_op == OpCopyRev);
                     reversed  <= (f_op == OpCopyRev);
                     if ((f_op == OpFill) || (f_op == OpChar)) fg_color <= f_x2[PW-1:0];
                     if (f_op == OpChar) bg_color <= f_y2[PW-1:0];
                     line_op_q <= (f_op == OpLine);
                     run_line  <= (f_op == OpLine);
                     run_rect  <= (f_op != OpLine);
                     state_q   <= StIssue;
                  end else begin
                     case (f_op)
                        OpSetDest: begin
                           dest_addr <= AW'({f_height, f_width});
                           dest_bpr  <= f_x1;
                        end
                        OpSetSrc: begin
                           src_addr <= AW'({f_height, f_width});
                           src_bpr  <= f_x1;
                        end
                        OpSetClip: begin
                           clip_x1 <= f_width;
                           clip_y1 <= f_height;
                           clip_x2 <= f_x1;
                           clip_y2 <= f_y1;
                        end
                        OpSetTrans: trans_color <= f_width[PW-1:0];
                        OpSetFont: begin
                           font_addr   <= AW'({f_height, f_width});
                           font_width  <= f_x1[4:0];
                           font_height <= f_y1[4:0];
                           font_bpr    <= f_x2[4:0];
                        end
                        // A fence in IDLE never has an outstanding draw, so it retires at once.
                        OpNop, OpFence: ;
                        default: bad_cmd <= 1'b1;
                     endcase
                  end
               end
            end
            StIssue: begin
               run_line <= 1'b0;
               run_rect <= 1'b0;
               state_q  <= StWait;
            end
            StWait: begin
               if (line_op_q ? line_done : rect_done) begin
                  cmd_count <= cmd_count + 32'd1;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_blit_cmd_queue.sv
// Bench for blit_cmd_queue: directed table, corner sequences and a randomized model check.
module tb_blit_cmd_queue;

   localparam int CW = 16;
   localparam int AW = 26;
   localparam int PW = 9;
   localparam int DEPTH = 8;

   logic clock = 1'b0;
   logic reset, stall, cmd_in_valid, cmd_in_ready, line_done, rect_done;
   logic [8+6*CW-1:0] cmd_in;
   logic [3:0] fifo_level;
   logic run_line, run_rect, reversed, textmode, mem_read, busy, bad_cmd;
   logic [CW-1:0] x1, y1, x2, y2, width, height, dest_bpr, src_bpr;
   logic [CW-1:0] clip_x1, clip_y1, clip_x2, clip_y2;
   logic [PW-1:0] fg_color, bg_color, trans_color;
   logic [AW-1:0] dest_addr, src_addr, font_addr;
   logic [4:0] font_width, font_height, font_bpr;
   logic [31:0] cmd_count;

   always #5 clock = ~clock;

   blit_cmd_queue #(.CW(CW), .AW(AW), .PW(PW), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .stall(stall), .cmd_in(cmd_in),
      .cmd_in_valid(cmd_in_valid), .cmd_in_ready(cmd_in_ready), .fifo_level(fifo_level),
      .run_line(run_line), .run_rect(run_rect), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
      .width(width), .height(height), .reversed(reversed), .textmode(textmode),
      .mem_read(mem_read), .fg_color(fg_color), .bg_color(bg_color),
      .trans_color(trans_color), .dest_addr(dest_addr), .src_addr(src_addr),
      .font_addr(font_addr), .dest_bpr(dest_bpr), .src_bpr(src_bpr), .clip_x1(clip_x1),
      .clip_y1(clip_y1), .clip_x2(clip_x2), .clip_y2(clip_y2), .font_width(font_width),
      .font_height(font_height), .font_bpr(font_bpr), .line_done(line_done),
      .rect_done(rect_done), .busy(busy), .cmd_count(cmd_count), .bad_cmd(bad_cmd)
   );

   typedef struct {
      logic [7:0]  op;
      logic [15:0] w, h, x1, y1, x2, y2;
   } cmd_t;

   typedef enum {SelDestAddr, SelDestBpr, SelSrcAddr, SelSrcBpr, SelClipX1, SelClipY1,
                 SelClipX2, SelClipY2, SelTrans, SelFontAddr, SelFontW, SelFontH,
                 SelFontBpr, SelBad, SelBusy} sel_e;

   typedef struct {
      cmd_t        c;
      sel_e        sel;
      logic [31:0] exp;
   } vec_t;

   int n_checks = 0;
   int n_err = 0;
   int rect_pulses = 0;
   int line_pulses = 0;

   // Model state for the randomized phase.
   cmd_t mq[$];
   longint m_dest, m_src, m_font, m_dbpr, m_sbpr, m_cx1, m_cy1, m_cx2, m_cy2;
   longint m_trans, m_fw, m_fh, m_fbpr, m_fg, m_bg, m_bad, m_draws;
   bit drv_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic cmd_t mk(input logic [7:0] op, input logic [15:0] w = 0,
                               input logic [15:0] h = 0, input logic [15:0] a = 0,
                               input logic [15:0] b = 0, input logic [15:0] c = 0,
                               input logic [15:0] d = 0);
      cmd_t r;
      r.op = op; r.w = w; r.h = h; r.x1 = a; r.y1 = b; r.x2 = c; r.y2 = d;
      return r;
   endfunction

   function automatic logic [8+6*CW-1:0] pack(input cmd_t c);
      return {c.op, c.y2, c.x2, c.y1, c.x1, c.h, c.w};
   endfunction

   function automatic logic [63:0] observe(input sel_e s);
      case (s)
         SelDestAddr: return 64'(dest_addr);
         SelDestBpr:  return 64'(dest_bpr);
         SelSrcAddr:  return 64'(src_addr);
         SelSrcBpr:   return 64'(src_bpr);
         SelClipX1:   return 64'(clip_x1);
         SelClipY1:   return 64'(clip_y1);
         SelClipX2:   return 64'(clip_x2);
         SelClipY2:   return 64'(clip_y2);
         SelTrans:    return 64'(trans_color);
         SelFontAddr: return 64'(font_addr);
         SelFontW:    return 64'(font_width);
         SelFontH:    return 64'(font_height);
         SelFontBpr:  return 64'(font_bpr);
         SelBad:      return 64'(bad_cmd);
         default:     return 64'(busy);
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_cmd(input cmd_t c);
      tick();
      cmd_in = pack(c);
      cmd_in_valid = 1'b1;
      tick();
      cmd_in_valid = 1'b0;
   endtask

   task automatic wait_run(input bit line, input string nm);
      int n = 0;
      while (!(line ? run_line : run_rect) && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) begin
         n_checks++;
         n_err++;
         $display("FAIL %s: no run pulse within 50 cycles", nm);
      end
   endtask

   // Counts issue events as rising edges of the run strobes.
   initial begin
      bit pr = 0, pl = 0;
      forever begin
         @(negedge clock);
         if (run_rect && !pr) rect_pulses++;
         if (run_line && !pl) line_pulses++;
         pr = run_rect;
         pl = run_line;
      end
   end

   function automatic bit is_draw_op(input logic [7:0] op);
      return op == 8'h03 || op == 8'h04 || op == 8'h05 || op == 8'h09 || op == 8'h0A;
   endfunction

   function automatic longint addr_of(input cmd_t c);
      return (longint'(c.h) * 65536 + longint'(c.w)) % 67108864;
   endfunction

   // Applies one command's effect on the visible context, straight from the opcode rules.
   task automatic model_apply(input cmd_t c);
      case (c.op)
         8'h01: begin m_dest = addr_of(c); m_dbpr = c.x1; end
         8'h02: begin m_src = addr_of(c); m_sbpr = c.x1; end
         8'h06: begin m_cx1 = c.w; m_cy1 = c.h; m_cx2 = c.x1; m_cy2 = c.y1; end
         8'h07: m_trans = c.w % 512;
         8'h08: begin m_font = addr_of(c); m_fw = c.x1 % 32; m_fh = c.y1 % 32;
                      m_fbpr = c.x2 % 32; end
         8'h03: begin m_fg = c.x2 % 512; m_draws++; end
         8'h09: begin m_fg = c.x2 % 512; m_bg = c.y2 % 512; m_draws++; end
         8'h04, 8'h05, 8'h0A: m_draws++;
         8'h00, 8'h0B: ;
         default: m_bad = 1;
      endcase
   endtask

   task automatic check_context(input string p);
      check({p, "_dest"}, {dest_addr, dest_bpr}, (m_dest << 16) | m_dbpr);
      check({p, "_src"}, {src_addr, src_bpr}, (m_src << 16) | m_sbpr);
      check({p, "_clip"}, {clip_x1, clip_y1, clip_x2, clip_y2},
            (m_cx1 << 48) | (m_cy1 << 32) | (m_cx2 << 16) | m_cy2);
      check({p, "_trans"}, trans_color, m_trans);
      check({p, "_font"}, {font_addr, font_width, font_height, font_bpr},
            (m_font << 15) | (m_fw << 10) | (m_fh << 5) | m_fbpr);
   endtask

   // On an issue strobe: retire model commands up to the next draw and compare everything.
   task automatic check_draw();
      cmd_t c;
      bit found = 0;
      while (mq.size() > 0 && !found) begin
         c = mq.pop_front();
         model_apply(c);
         found = is_draw_op(c.op);
      end
      if (!found) begin
         n_checks++;
         n_err++;
         $display("FAIL rnd_unexpected_run: run_line=%0b run_rect=%0b, no draw queued",
                  run_line, run_rect);
         return;
      end
      check("rnd_kind", {run_line, run_rect}, (c.op == 8'h0A) ? 2'b10 : 2'b01);
      check("rnd_operands", {x1, y1, x2, y2, width, height},
            {c.x1, c.y1, c.x2, c.y2, c.w, c.h});
      check("rnd_flags", {reversed, textmode, mem_read},
            {c.op == 8'h05, c.op == 8'h09, c.op == 8'h04 || c.op == 8'h05});
      check("rnd_colors", {fg_color, bg_color}, (m_fg << 9) | m_bg);
      check_context("rnd_ctx");
   endtask

   function automatic cmd_t rand_cmd();
      cmd_t c;
      int r = $urandom_range(0, 99);
      c.op = (r < 4) ? ((r < 2) ? 8'hFF : 8'h0C) : 8'($urandom_range(0, 11));
      c.w = 16'($urandom); c.h = 16'($urandom); c.x1 = 16'($urandom);
      c.y1 = 16'($urandom); c.x2 = 16'($urandom); c.y2 = 16'($urandom);
      return c;
   endfunction

   initial begin
      vec_t vt[$];
      int p0;
      reset = 1'b1; stall = 1'b0; cmd_in = '0; cmd_in_valid = 1'b0;
      line_done = 1'b0; rect_done = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clock);
      check("reset_level", fifo_level, 0);
      check("reset_flags", {busy, run_line, run_rect, bad_cmd, cmd_in_ready}, 5'b00001);
      check("reset_count", cmd_count, 0);
      check("reset_ctx", {dest_addr, trans_color, fg_color, clip_x2}, 0);

      // Set-command vectors: {command, observed output, expected value}.
      vt.push_back('{mk(8'h01, 16'h3456, 16'h0012, 16'd640), SelDestAddr, 32'h0123456});
      vt.push_back('{mk(8'h01, 16'h3456, 16'h0012, 16'd640), SelDestBpr, 32'd640});
      vt.push_back('{mk(8'h01, 16'h3456, 16'h0012, 16'd640), SelBusy, 32'd0});
      vt.push_back('{mk(8'h02, 16'hABCD, 16'hFFFF, 16'h1234), SelSrcAddr, 32'h3FFABCD});
      vt.push_back('{mk(8'h02, 16'hABCD, 16'hFFFF, 16'h1234), SelSrcBpr, 32'h1234});
      vt.push_back('{mk(8'h06, 16'd10, 16'd20, 16'd300, 16'd200), SelClipX1, 32'd10});
      vt.push_back('{mk(8'h06, 16'd10, 16'd20, 16'd300, 16'd200), SelClipY1, 32'd20});
      vt.push_back('{mk(8'h06, 16'd10, 16'd20, 16'd300, 16'd200), SelClipX2, 32'd300});
      vt.push_back('{mk(8'h06, 16'd10, 16'd20, 16'd300, 16'd200), SelClipY2, 32'd200});
      vt.push_back('{mk(8'h07, 16'hFFAA), SelTrans, 32'h1AA});
      vt.push_back('{mk(8'h08, 16'h2, 16'h1, 16'h27, 16'h10, 16'h33), SelFontAddr, 32'h10002});
      vt.push_back('{mk(8'h08, 16'h2, 16'h1, 16'h27, 16'h10, 16'h33), SelFontW, 32'h7});
      vt.push_back('{mk(8'h08, 16'h2, 16'h1, 16'h27, 16'h10, 16'h33), SelFontH, 32'h10});
      vt.push_back('{mk(8'h08, 16'h2, 16'h1, 16'h27, 16'h10, 16'h33), SelFontBpr, 32'h13});
      vt.push_back('{mk(8'h00), SelBad, 32'd0});
      vt.push_back('{mk(8'h0B), SelBusy, 32'd0});
      vt.push_back('{mk(8'hFF), SelBad, 32'd1});
      vt.push_back('{mk(8'hFF), SelBusy, 32'd0});
      vt.push_back('{mk(8'h01, 16'h1, 16'h0, 16'h20), SelDestAddr, 32'd1});
      vt.push_back('{mk(8'h01, 16'h1, 16'h0, 16'h20), SelBad, 32'd1});
      foreach (vt[i]) begin
         push_cmd(vt[i].c);
         @(negedge clock);
         @(negedge clock);
         check($sformatf("vec%0d_%s", i, vt[i].sel.name()), observe(vt[i].sel), vt[i].exp);
      end

      // FILL: single issue, done during ISSUE and a non-matching done are both ignored.
      p0 = rect_pulses;
      push_cmd(mk(8'h03, 16'd5, 16'd6, 16'd7, 16'd8, 16'h01F5, 16'd0));
      wait_run(1'b0, "fill_run");
      check("fill_fg", fg_color, 9'h1F5);
      check("fill_operands", {width, height, mem_read, textmode}, {16'd5, 16'd6, 2'b00});
      rect_done = 1'b1;
      tick();
      rect_done = 1'b0;
      line_done = 1'b1;
      tick();
      line_done = 1'b0;
      repeat (3) tick();
      @(negedge clock);
      check("fill_wait", {busy, run_rect, cmd_count}, {2'b10, 32'd0});
      check("fill_pulses", rect_pulses - p0, 1);
      rect_done = 1'b1;
      @(negedge clock);
      rect_done = 1'b0;
      check("fill_done", {busy, cmd_count}, {1'b0, 32'd1});

      // LINE followed by SET_TRANS: the context change waits for line_done.
      p0 = line_pulses;
      push_cmd(mk(8'h0A, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6));
      push_cmd(mk(8'h07, 16'h00AA));
      repeat (20) @(negedge clock);
      check("line_trans_held", trans_color, 9'h1AA);
      check("line_queued", {fifo_level, 28'(line_pulses - p0)}, {4'd1, 28'd1});
      line_done = 1'b1;
      @(negedge clock);
      line_done = 1'b0;
      @(negedge clock);
      check("line_trans_new", trans_color, 9'h0AA);
      check("line_count", {busy, cmd_count}, {1'b0, 32'd2});

      // Full FIFO under stall: the ninth push must be dropped.
      @(negedge clock);
      stall = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (i == 8) check("full_after8", {cmd_in_ready, fifo_level}, {1'b0, 4'd8});
         cmd_in = pack(mk(8'h01, 16'(i + 1)));
         cmd_in_valid = 1'b1;
      end
      tick();
      cmd_in_valid = 1'b0;
      check("full_level", fifo_level, 8);
      stall = 1'b0;
      for (int n = 0; n < 40 && busy; n++) @(negedge clock);
      check("full_drain", {busy, fifo_level}, 0);
      check("full_last_dest", dest_addr, 26'd8);

      // Stall during ISSUE keeps run_rect high yet counts as one issue.
      p0 = rect_pulses;
      push_cmd(mk(8'h03, 16'd1, 16'd1, 16'd1, 16'd1, 16'h0055, 16'd0));
      wait_run(1'b0, "stall_run");
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check($sformatf("stall_hold%0d", i), run_rect, 1'b1);
      end
      stall = 1'b0;
      @(negedge clock);
      check("stall_release", {run_rect, busy}, 2'b01);
      @(negedge clock);
      check("stall_pulses", rect_pulses - p0, 1);

      // Reset while in WAIT drops the draw; a later rect_done is ignored.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("wreset_state", {busy, cmd_count, fg_color, dest_addr}, 0);
      rect_done = 1'b1;
      @(negedge clock);
      rect_done = 1'b0;
      @(negedge clock);
      check("wreset_done_ignored", {busy, run_rect, cmd_count}, 0);

      // Randomized stream against the command-level model.
      m_dest = 0; m_src = 0; m_font = 0; m_dbpr = 0; m_sbpr = 0; m_cx1 = 0; m_cy1 = 0;
      m_cx2 = 0; m_cy2 = 0; m_trans = 0; m_fw = 0; m_fh = 0; m_fbpr = 0; m_fg = 0;
      m_bg = 0; m_bad = 0; m_draws = 0; drv_done = 0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               cmd_t c = rand_cmd();
               bit acc = 0;
               tick();
               cmd_in = pack(c);
               cmd_in_valid = 1'b1;
               while (!acc) begin
                  bit rdy = cmd_in_ready;
                  tick();
                  if (rdy) begin
                     acc = 1;
                     mq.push_back(c);
                  end
               end
               cmd_in_valid = 1'b0;
               repeat ($urandom_range(0, 2)) tick();
            end
            drv_done = 1;
         end
         begin
            int guard = 0;
            while (!(drv_done && !busy) && guard < 20000) begin
               @(negedge clock);
               guard++;
               if (run_rect || run_line) begin
                  bit is_line = run_line;
                  check_draw();
                  tick();
                  if ($urandom_range(0, 3) == 0) begin
                     if (is_line) rect_done = 1'b1; else line_done = 1'b1;
                     tick();
                     rect_done = 1'b0; line_done = 1'b0;
                  end
                  repeat ($urandom_range(0, 3)) tick();
                  if (is_line) line_done = 1'b1; else rect_done = 1'b1;
                  tick();
                  rect_done = 1'b0; line_done = 1'b0;
               end
            end
            if (guard >= 20000) begin
               n_checks++;
               n_err++;
               $display("FAIL rnd_timeout: busy=%0b level=%0d", busy, fifo_level);
            end
         end
      join
      while (mq.size() > 0) model_apply(mq.pop_front());
      @(negedge clock);
      check_context("rnd_final");
      check("rnd_final_count", cmd_count, m_draws);
      check("rnd_final_bad", bad_cmd, m_bad);
      check("rnd_final_colors", {fg_color, bg_color}, (m_fg << 9) | m_bg);
      check("rnd_final_idle", {busy, fifo_level}, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
